// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared types and helpers for the RAM stream reader.
//   rsr_state_e : sequencer state (IDLE, RUN, DRAIN)
//   addr_w()    : address width for a given RAM depth
package ram_stream_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rsr_state_e;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rsr_skid_buf.sv
// rsr_skid_buf: 2-entry valid/ready buffer with a fall-through path.
// When the buffer is empty the pushed word is presented directly at the head,
// so a word arriving from the RAM can be accepted in the cycle it arrives.
// Words not accepted are stored and drained in order.
// Ports:
//   i_clk, i_rstn        : clock, synchronous active-low reset
//   i_push, i_push_data  : incoming word (no back-pressure; caller must not overfill)
//   i_pop                : downstream ready
//   o_valid, o_data      : head of buffer
//   o_count              : number of stored words (0..2), excluding a bypassed push
module rsr_skid_buf #(
    parameter int unsigned WIDTH_P = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_push,
    input  logic [WIDTH_P-1:0] i_push_data,
    input  logic               i_pop,
    output logic               o_valid,
    output logic [WIDTH_P-1:0] o_data,
    output logic [1:0]         o_count
);

    logic [WIDTH_P-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;

    logic w_empty;
    logic w_pop;
    logic w_bypass;
    logic w_store;
    logic w_deq;

    assign w_empty  = (r_count == 2'd0);
    assign o_valid  = !w_empty || i_push;
    assign o_data   = w_empty ? i_push_data : r_mem[r_rd_ptr];
    assign o_count  = r_count;

    assign w_pop    = i_pop && o_valid;
    // Empty buffer and the head is taken: the pushed word never lands.
    assign w_bypass = w_empty && w_pop;
    assign w_store  = i_push && !w_bypass;
    assign w_deq    = w_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: read-side sequencer for the dual-port sample RAM.
// Accepts (base, len) commands, issues sequential wrapping RAM reads, absorbs
// the 1-cycle RAM latency through rsr_skid_buf and emits a valid/ready stream
// with last_o on the final sample and a done_o pulse after it is accepted.
// Ports:
//   rd_clk_i, rd_rstn_i            : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o        : command handshake
//   cmd_base_i, cmd_len_i          : first address, sample count (0..DEPTH_P)
//   ram_rd_en_o, ram_rd_addr_o     : RAM read port request
//   ram_rd_data_i                  : RAM data, valid the cycle after ram_rd_en_o
//   data_o/valid_o/ready_i/last_o  : output stream
//   busy_o, done_o                 : status
// Optional feature, macro RAM_STREAM_READER_LOOP_EN: adds loop_i (sampled at the
// command handshake, repeats the pass) and stop_i (ends looping after the pass).
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned DEPTH_P = 512
) (
    input  logic                        rd_clk_i,
    input  logic                        rd_rstn_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [addr_w(DEPTH_P)-1:0]  cmd_base_i,
    input  logic [addr_w(DEPTH_P):0]    cmd_len_i,
`ifdef RAM_STREAM_READER_LOOP_EN
    input  logic                        loop_i,
    input  logic                        stop_i,
`endif
    output logic                        ram_rd_en_o,
    output logic [addr_w(DEPTH_P)-1:0]  ram_rd_addr_o,
    input  logic [WIDTH_P-1:0]          ram_rd_data_i,
    output logic [WIDTH_P-1:0]          data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned AW = addr_w(DEPTH_P);
    localparam int unsigned LW = AW + 1;
`ifdef RAM_STREAM_READER_LOOP_EN
    // Remaining-sample count spans the current pass plus the next one.
    localparam int unsigned CW = LW + 1;
`else
    localparam int unsigned CW = LW;
`endif
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH_P - 1);

    rsr_state_e    r_state;
    logic          r_cmd_ready;
    logic          r_done;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_issue_cnt;
    logic [CW-1:0] r_out_cnt;
    logic          r_in_flight;

    logic               w_cmd_fire;
    logic               w_issue;
    logic               w_accept;
    logic               w_last;
    logic [1:0]         w_occ;
    logic [AW-1:0]      w_addr_next;
    logic [CW-1:0]      w_out_cnt_d;
    logic               w_buf_valid;
    logic [WIDTH_P-1:0] w_buf_data;
    logic [1:0]         w_buf_cnt;

`ifdef RAM_STREAM_READER_LOOP_EN
    logic [AW-1:0] r_base;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_pos_cnt;
    logic          r_loop;
    logic          w_reload;

    assign w_reload = w_issue && (r_issue_cnt == LW'(1)) && r_loop && !stop_i;
    assign w_last   = (r_pos_cnt == LW'(1));
`else
    assign w_last   = (r_out_cnt == CW'(1));
`endif

    assign w_cmd_fire  = cmd_valid_i && r_cmd_ready;
    // Stored words plus the word currently coming out of the RAM.
    assign w_occ       = w_buf_cnt + {1'b0, r_in_flight};
    assign w_issue     = (r_state == RUN) && (r_issue_cnt != '0) && (w_occ < 2'd2);
    assign w_accept    = w_buf_valid && ready_i;
    // Explicit compare so non-power-of-two depths wrap correctly.
    assign w_addr_next = (r_addr == ADDR_LAST) ? '0 : r_addr + AW'(1);

    always_comb begin
        w_out_cnt_d = r_out_cnt;
        if (w_accept) begin
            w_out_cnt_d = w_out_cnt_d - CW'(1);
        end
`ifdef RAM_STREAM_READER_LOOP_EN
        if (w_reload) begin
            w_out_cnt_d = w_out_cnt_d + CW'(r_len);
        end
`endif
    end

    always_ff @(posedge rd_clk_i) begin
        if (!rd_rstn_i) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_in_flight <= 1'b0;
`ifdef RAM_STREAM_READER_LOOP_EN
            r_base      <= '0;
            r_len       <= '0;
            r_pos_cnt   <= '0;
            r_loop      <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_in_flight <= w_issue;
            r_out_cnt   <= w_out_cnt_d;
`ifdef RAM_STREAM_READER_LOOP_EN
            if (w_accept) begin
                r_pos_cnt <= (r_pos_cnt == LW'(1)) ? r_len : r_pos_cnt - LW'(1);
            end
`endif
            unique case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        if (cmd_len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            r_cmd_ready <= 1'b0;
                            r_addr      <= cmd_base_i;
                            r_issue_cnt <= cmd_len_i;
                            r_out_cnt   <= CW'(cmd_len_i);
`ifdef RAM_STREAM_READER_LOOP_EN
                            r_base      <= cmd_base_i;
                            r_len       <= cmd_len_i;
                            r_pos_cnt   <= cmd_len_i;
                            r_loop      <= loop_i;
`endif
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_addr      <= w_addr_next;
                        r_issue_cnt <= r_issue_cnt - LW'(1);
                        if (r_issue_cnt == LW'(1)) begin
`ifdef RAM_STREAM_READER_LOOP_EN
                            if (w_reload) begin
                                r_addr      <= r_base;
                                r_issue_cnt <= r_len;
                            end else begin
                                r_state <= DRAIN;
                            end
`else
                            r_state <= DRAIN;
`endif
                        end
                    end
`ifdef RAM_STREAM_READER_LOOP_EN
                    if (stop_i) begin
                        r_loop <= 1'b0;
                    end
`endif
                end
                DRAIN: begin
                    if (w_accept && (r_out_cnt == CW'(1))) begin
                        r_state     <= IDLE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    rsr_skid_buf #(
        .WIDTH_P(WIDTH_P)
    ) u_skid (
        .i_clk      (rd_clk_i),
        .i_rstn     (rd_rstn_i),
        .i_push     (r_in_flight),
        .i_push_data(ram_rd_data_i),
        .i_pop      (ready_i),
        .o_valid    (w_buf_valid),
        .o_data     (w_buf_data),
        .o_count    (w_buf_cnt)
    );

    assign cmd_ready_o   = r_cmd_ready;
    assign ram_rd_en_o   = w_issue;
    assign ram_rd_addr_o = r_addr;
    assign valid_o       = w_buf_valid;
    // Zero when idle so the stream reads as reset values between bursts.
    assign data_o        = w_buf_valid ? w_buf_data : '0;
    assign last_o        = w_buf_valid && w_last;
    assign busy_o        = (r_state != IDLE);
    assign done_o        = r_done;

endmodule
